mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width of both requesters and the RAM port.
REQ-002 SHALL have parameter HOLD_MAX, default 4, maximum consecutive accepts for one requester while the other is waiting (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_valid/m1_valid  input  1  each requester has a request pending.
REQ-006 SHALL have ports m0_ready/m1_ready  output  1  request accepted this cycle when ready and valid are both high.
REQ-007 SHALL have ports m0_write/m1_write  input  1  request is a store (1) or a load (0).
REQ-008 SHALL have ports m0_addr/m1_addr  input  AW  word address.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  32  store data.
REQ-010 SHALL have ports m0_rsp_valid/m1_rsp_valid  output  1  one-cycle load-data pulse.
REQ-011 SHALL have ports m0_rdata/m1_rdata  output  32  load data; valid only with the matching rsp_valid.
REQ-012 SHALL have ports ram_read, ram_write  output  1  strobes to the shared single-port data RAM.
REQ-013 SHALL have ports ram_addr  output  AW and ram_wdata  output  32  RAM address and store data.
REQ-014 SHALL have port ram_rdata  input  32  combinational RAM read data.

Function
REQ-015 SHALL accept at most one request per cycle; the grant is combinational from this cycle's valids and registered state.
REQ-016 SHALL drive ram_addr, ram_wdata, ram_read = ~write and ram_write = write from the granted requester in the accept cycle, with both strobes 0 when nothing is accepted.
REQ-017 SHALL complete a store in its accept cycle (the RAM writes at that posedge); stores produce no response.
REQ-018 SHALL register ram_rdata at the accept-cycle posedge and pulse the requester's rsp_valid with that data in the next cycle (load latency 1 cycle).
REQ-019 SHALL allow back-to-back accepts every cycle, including a load followed by a store to the same address; the load returns the pre-store data.
REQ-020 SHALL grant the only valid requester when exactly one is valid.
REQ-021 SHALL, when both are valid, grant the requester not granted most recently (last-grant pointer; initial pointer value favours m0).
REQ-022 SHALL keep a 4-bit hold counter that increments on each consecutive accept of the same requester while the other is valid, and resets to 0 on a grant change or when the other is not valid.
REQ-023 SHALL force a grant to the waiting requester once the counter reaches HOLD_MAX (only reachable in fixed-priority mode).
REQ-024 SHALL never assert m0_ready and m1_ready in the same cycle, and never assert ready for a requester whose valid is low.
REQ-025 SHALL keep the rsp_valid outputs mutually exclusive and each a single-cycle pulse.

Reset
REQ-026 SHALL, while rst is high at posedge clk, clear the last-grant pointer (m0 favoured), the hold counter, both rsp_valid and both rdata registers to 0.
REQ-027 SHALL force ready, ram_read and ram_write to 0 in any cycle where rst is high, so no request is accepted.
REQ-028 SHALL discard a load accepted in the cycle before reset asserts: no rsp_valid after reset.

Configuration
REQ-029 SHALL use macro MEM_ARB_RR_EN: when defined, contention is resolved round-robin per REQ-021.
REQ-030 SHALL, when MEM_ARB_RR_EN is undefined, make m0 fixed priority under contention, with m1 protected from starvation only by the HOLD_MAX force of REQ-023.

Verification
REQ-031 SHALL cover: m0 load from addr 0x10 holding 0xDEADBEEF, m1 idle -> m0_ready in cycle 0, m0_rsp_valid with 0xDEADBEEF in cycle 1, m1 outputs 0.
REQ-032 SHALL cover: both valid for 6 cycles with MEM_ARB_RR_EN defined -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-033 SHALL cover: both valid continuously without the macro and HOLD_MAX=4 -> grants m0 x4, then m1 x1, repeating.
REQ-034 SHALL cover: m1 store 0x12345678 to addr 0x20, then m0 load of 0x20 next cycle -> ram_write in cycle 0, m0_rdata 0x12345678 in cycle 2.
REQ-035 SHALL cover: m0 load accepted, rst high in the next cycle -> no m0_rsp_valid, all outputs 0, and m0 wins the first contention after reset.

Source files
------------

// File: rtl/mem_arb_if.sv
// Bus bundle between two memory requesters, the arbiter and a shared single-port RAM.
// Handshake: a request transfers in a cycle where mX_valid and mX_ready are both high;
// valid may not depend on ready, ready is a same-cycle response, and rsp_valid is a
// one-cycle pulse qualifying rdata. ram_* strobes are high only in the transfer cycle.
interface mem_arb_if #(
  parameter int AW = 32
);
  logic          m0_valid;
  logic          m0_ready;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_rsp_valid;
  logic [31:0]   m0_rdata;

  logic          m1_valid;
  logic          m1_ready;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_rsp_valid;
  logic [31:0]   m1_rdata;

  logic          ram_read;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  modport slave (
    input  m0_valid, m0_write, m0_addr, m0_wdata,
    output m0_ready, m0_rsp_valid, m0_rdata,
    input  m1_valid, m1_write, m1_addr, m1_wdata,
    output m1_ready, m1_rsp_valid, m1_rdata,
    output ram_read, ram_write, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_valid, m0_write, m0_addr, m0_wdata,
    input  m0_ready, m0_rsp_valid, m0_rdata,
    output m1_valid, m1_write, m1_addr, m1_wdata,
    input  m1_ready, m1_rsp_valid, m1_rdata,
    input  ram_read, ram_write, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_arb.sv
// Two-requester arbiter for a shared single-port RAM with 1-cycle load responses.
// MEM_ARB_RR_EN defined: round-robin under contention; undefined: m0 priority with HOLD_MAX anti-starvation.
module mem_arb #(
  parameter int AW       = 32,
  parameter int HOLD_MAX = 4
) (
  input logic       clk,
  input logic       rst,
  mem_arb_if.slave  bus
);
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  // ptr_q = 1 means m0 was granted most recently, so m1 is favoured next.
  logic        ptr_q, ptr_d;
  logic [3:0]  hold_q, hold_d;
  logic        rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          both, at_limit, accept, gnt_m1, same;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  always_comb begin
    both     = bus.m0_valid & bus.m1_valid;
    at_limit = (hold_q >= HOLD_LIM);
    accept   = ~rst & (bus.m0_valid | bus.m1_valid);
    if (both) begin
`ifdef MEM_ARB_RR_EN
      gnt_m1 = ptr_q;
`else
      gnt_m1 = ptr_q & at_limit;
`endif
    end else begin
      gnt_m1 = bus.m1_valid;
    end
    same      = gnt_m1 ^ ptr_q;
    sel_write = gnt_m1 ? bus.m1_write : bus.m0_write;
    sel_addr  = gnt_m1 ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = gnt_m1 ? bus.m1_wdata : bus.m0_wdata;
  end

  always_comb begin
    bus.m0_ready  = accept & ~gnt_m1;
    bus.m1_ready  = accept & gnt_m1;
    bus.ram_read  = accept & ~sel_write;
    bus.ram_write = accept & sel_write;
    bus.ram_addr  = accept ? sel_addr  : '0;
    bus.ram_wdata = accept ? sel_wdata : '0;
    // A response registered just before reset must not escape during the reset cycle.
    bus.m0_rsp_valid = rsp0_q & ~rst;
    bus.m1_rsp_valid = rsp1_q & ~rst;
    bus.m0_rdata     = rst ? '0 : rdata0_q;
    bus.m1_rdata     = rst ? '0 : rdata1_q;
  end

  always_comb begin
    ptr_d    = ptr_q;
    hold_d   = 4'd0;
    rsp0_d   = 1'b0;
    rsp1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (accept) begin
      ptr_d = ~gnt_m1;
      // The first accept of a run counts as 1, so HOLD_MAX accepts happen before the force.
      if (both) begin
        hold_d = same ? ((hold_q == 4'hf) ? hold_q : hold_q + 4'd1) : 4'd1;
      end
      if (!sel_write) begin
        if (gnt_m1) begin
          rsp1_d   = 1'b1;
          rdata1_d = bus.ram_rdata;
        end else begin
          rsp0_d   = 1'b1;
          rdata0_d = bus.ram_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= 1'b0;
      hold_q   <= 4'd0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rsp0_q   <= rsp0_d;
      rsp1_q   <= rsp1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: loads, stores, back-to-back hazards, contention and reset discard.
module tb_mem_arb;
  localparam int AW = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_arb_if #(.AW(AW)) bus ();

  mem_arb #(.AW(AW), .HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write at posedge, preloaded while in reset.
  logic [31:0] mem [0:255];
  assign bus.ram_rdata = mem[bus.ram_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hAAAA5555;
    end else if (bus.ram_write) begin
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.m0_valid = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_valid = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic req0(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    bus.m0_valid = 1'b1; bus.m0_write = wr; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic req1(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    bus.m1_valid = 1'b1; bus.m1_write = wr; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] exp_m1;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
`ifdef MEM_ARB_RR_EN
    exp_m1 = 10'b1010101010;
`else
    exp_m1 = 10'b1000010000;
`endif

    // Reset holds off a pending request.
    req0(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rst_m0_ready", 32'(bus.m0_ready), 32'h0);
    check("rst_ram_read", 32'(bus.ram_read), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("idle_m0_rsp", 32'(bus.m0_rsp_valid), 32'h0);
    check("idle_m0_rdata", bus.m0_rdata, 32'h0);
    check("idle_ram_write", 32'(bus.ram_write), 32'h0);
    next_cycle();

    // m0 load from 0x10, m1 idle.
    req0(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("ld_m0_ready", 32'(bus.m0_ready), 32'h1);
    check("ld_m1_ready", 32'(bus.m1_ready), 32'h0);
    check("ld_ram_read", 32'(bus.ram_read), 32'h1);
    check("ld_ram_addr", bus.ram_addr, 32'h10);
    next_cycle();
    idle();
    @(negedge clk);
    check("ld_m0_rsp", 32'(bus.m0_rsp_valid), 32'h1);
    check("ld_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("ld_m1_rsp", 32'(bus.m1_rsp_valid), 32'h0);
    check("ld_m1_rdata", bus.m1_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    check("ld_rsp_pulse", 32'(bus.m0_rsp_valid), 32'h0);
    next_cycle();

    // m1 store to 0x20, then m0 loads 0x20.
    req1(1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    check("st_m1_ready", 32'(bus.m1_ready), 32'h1);
    check("st_ram_write", 32'(bus.ram_write), 32'h1);
    check("st_ram_read", 32'(bus.ram_read), 32'h0);
    check("st_ram_wdata", bus.ram_wdata, 32'h12345678);
    next_cycle();
    idle();
    req0(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("raw_m0_ready", 32'(bus.m0_ready), 32'h1);
    check("st_no_m1_rsp", 32'(bus.m1_rsp_valid), 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("raw_m0_rsp", 32'(bus.m0_rsp_valid), 32'h1);
    check("raw_m0_rdata", bus.m0_rdata, 32'h12345678);
    next_cycle();

    // Load then store to the same address back to back: load sees old data.
    req0(1'b0, 32'h30, 32'h0);
    @(negedge clk);
    check("war_m0_ready", 32'(bus.m0_ready), 32'h1);
    next_cycle();
    idle();
    req1(1'b1, 32'h30, 32'h11112222);
    @(negedge clk);
    check("war_m1_ready", 32'(bus.m1_ready), 32'h1);
    check("war_ram_write", 32'(bus.ram_write), 32'h1);
    check("war_m0_rsp", 32'(bus.m0_rsp_valid), 32'h1);
    check("war_m0_rdata", bus.m0_rdata, 32'hAAAA5555);
    next_cycle();
    idle();
    @(negedge clk);
    check("war_m1_no_rsp", 32'(bus.m1_rsp_valid), 32'h0);
    next_cycle();

    // Continuous contention with stores; last grant was m1 so m0 goes first.
    for (int i = 0; i < 10; i++) begin
      req0(1'b1, 32'h40, 32'h100 + 32'(i));
      req1(1'b1, 32'h41, 32'h200 + 32'(i));
      @(negedge clk);
      check($sformatf("arb_m1_ready[%0d]", i), 32'(bus.m1_ready), 32'(exp_m1[i]));
      check($sformatf("arb_m0_ready[%0d]", i), 32'(bus.m0_ready), 32'(!exp_m1[i]));
      check($sformatf("arb_wdata[%0d]", i), bus.ram_wdata,
            exp_m1[i] ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
      next_cycle();
    end
    idle();

    // Only m1 valid.
    req1(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("solo_m1_ready", 32'(bus.m1_ready), 32'h1);
    check("solo_m0_ready", 32'(bus.m0_ready), 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("solo_m1_rsp", 32'(bus.m1_rsp_valid), 32'h1);
    check("solo_m1_rdata", bus.m1_rdata, 32'hDEADBEEF);
    check("solo_m0_rsp", 32'(bus.m0_rsp_valid), 32'h0);
    next_cycle();

    // m0 load accepted, reset in the following cycle discards its response.
    req0(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rd_m0_ready", 32'(bus.m0_ready), 32'h1);
    next_cycle();
    rst = 1'b1;
    req1(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rd_rst_m0_rsp", 32'(bus.m0_rsp_valid), 32'h0);
    check("rd_rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("rd_rst_m0_ready", 32'(bus.m0_ready), 32'h0);
    check("rd_rst_m1_ready", 32'(bus.m1_ready), 32'h0);
    check("rd_rst_ram_read", 32'(bus.ram_read), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rd_post_m0_ready", 32'(bus.m0_ready), 32'h1);
    check("rd_post_m1_ready", 32'(bus.m1_ready), 32'h0);
    check("rd_post_m0_rsp", 32'(bus.m0_rsp_valid), 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_post_rsp", 32'(bus.m0_rsp_valid), 32'h1);
    check("rd_post_rdata", bus.m0_rdata, 32'hDEADBEEF);
    check("rd_post_m1_rsp", 32'(bus.m1_rsp_valid), 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
